// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - sequential unsigned divider with zero and power-of-two fast paths
module seq_divider #(
  parameter int DW = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [(1<<DW)-1:0]  I,
  input  logic [(1<<DW)-1:0]  D,
  output logic [(1<<DW)-1:0]  Q,
  output logic [(1<<DW)-1:0]  R,
  output logic                busy,
  output logic                done,
  output logic                div_by_zero
);

  localparam int N = 1 << DW;
  localparam logic [N-1:0] ONE_N = 1;
  localparam logic [DW:0]  ONE_C = 1;
  localparam logic [DW:0]  CNT_LOAD = N[DW:0];

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t        state_q, state_d;
  // dvd_q shifts dividend bits out at the top and quotient bits in at the bottom
  logic [N-1:0]  dvd_q, dvd_d;
  logic [N-1:0]  dvs_q, dvs_d;
  logic [N-1:0]  rem_q, rem_d;
  logic [DW:0]   cnt_q, cnt_d;
  logic [N-1:0]  q_q, q_d;
  logic [N-1:0]  r_q, r_d;
  logic          dbz_q, dbz_d;

  logic [N:0]    shifted;
  logic [N-1:0]  diff;
  logic          qbit;
  logic          one_hot;
  logic [DW-1:0] shamt;

  assign Q           = q_q;
  assign R           = r_q;
  assign div_by_zero = dbz_q;
  assign busy        = (state_q == CALC);
  assign done        = (state_q == FIN);

  // One restoring step on the partial remainder, plus power-of-two detection on D
  always_comb begin
    shifted = {rem_q, dvd_q[N-1]};
    // When qbit is set the true difference is below dvs_q, so the low N bits are exact
    diff    = shifted[N-1:0] - dvs_q;
    qbit    = (shifted >= {1'b0, dvs_q});
    one_hot = (D != '0) && ((D & (D - ONE_N)) == '0);
    shamt   = '0;
    for (int k = 0; k < N; k++) begin
      if (D[k]) shamt = k[DW-1:0];
    end
  end

  // Next-state and datapath updates; results only move when FIN is entered
  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE, FIN: begin
        state_d = IDLE;
        if (start) begin
          dvd_d = I;
          dvs_d = D;
          if (D == '0) begin
            q_d     = '1;
            r_d     = I;
            dbz_d   = 1'b1;
            state_d = FIN;
          end else if (one_hot) begin
            q_d     = I >> shamt;
            r_d     = I & ~({N{1'b1}} << shamt);
            dbz_d   = 1'b0;
            state_d = FIN;
          end else begin
            rem_d   = '0;
            cnt_d   = CNT_LOAD;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        dvd_d = {dvd_q[N-2:0], qbit};
        rem_d = qbit ? diff : shifted[N-1:0];
        cnt_d = cnt_q - ONE_C;
        if (cnt_q == ONE_C) begin
          q_d     = {dvd_q[N-2:0], qbit};
          r_d     = qbit ? diff : shifted[N-1:0];
          dbz_d   = 1'b0;
          state_d = FIN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, cleared immediately by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dbz_q   <= dbz_d;
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - scoreboard bench for seq_divider
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] I, D, Q, R;
  logic        busy, done, div_by_zero;

  typedef struct packed {
    logic [15:0] q;
    logic [15:0] r;
    logic        z;
  } exp_t;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];
  exp_t last_exp = '0;
  exp_t mon_e;

  seq_divider #(.DW(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .I(I), .D(D),
    .Q(Q), .R(R), .busy(busy), .done(done), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [15:0] q, input logic [15:0] r, input logic z);
    exp_t e;
    e.q = q; e.r = r; e.z = z;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on each done pulse, checks held outputs while busy
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) begin
        chk("done_busy_overlap", {31'd0, busy}, 32'd0);
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done actual=1 required=0");
        end else begin
          mon_e = sb.pop_front();
          chk("Q", {16'd0, Q}, {16'd0, mon_e.q});
          chk("R", {16'd0, R}, {16'd0, mon_e.r});
          chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, mon_e.z});
          last_exp = mon_e;
        end
      end else if (busy) begin
        chk("hold_Q", {16'd0, Q}, {16'd0, last_exp.q});
        chk("hold_R", {16'd0, R}, {16'd0, last_exp.r});
        chk("hold_dbz", {31'd0, div_by_zero}, {31'd0, last_exp.z});
      end
    end
  end

  // Called at a negedge; drives start for one edge, then scrambles the inputs
  task automatic issue(input logic [15:0] i, input logic [15:0] d, input exp_t e);
    I = i;
    D = d;
    start = 1'b1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    I = 16'($urandom);
    D = 16'($urandom);
  endtask

  task automatic wait_done(input int exp_lat, input int exp_busy, input string tag);
    int lat = 0;
    int bc = 0;
    bit seen = 1'b0;
    while (!seen && lat < 40) begin
      @(negedge clk);
      lat++;
      if (busy) bc++;
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=no_done required=done", tag);
    end else if (exp_lat >= 0) begin
      chk({tag, "_latency"}, lat, exp_lat);
      chk({tag, "_busy_cycles"}, bc, exp_busy);
    end
  endtask

  task automatic run(input logic [15:0] i, input logic [15:0] d, input logic [15:0] eq,
                     input logic [15:0] er, input logic ez, input int lat, input int bsy,
                     input string tag);
    issue(i, d, mk(eq, er, ez));
    wait_done(lat, bsy, tag);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_Q"}, {16'd0, Q}, 32'd0);
    chk({tag, "_R"}, {16'd0, R}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_dbz"}, {31'd0, div_by_zero}, 32'd0);
  endtask

  initial begin
    logic [15:0] si, sd;
    int          pick;
    rst_n = 1'b0;
    start = 1'b0;
    I = '0;
    D = '0;
    #12;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    run(16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 17, 16, "g100_7");
    @(negedge clk);
    run(16'd1000, 16'd8, 16'd125, 16'd0, 1'b0, 1, 0, "p1000_8");
    run(16'd65535, 16'd1, 16'd65535, 16'd0, 1'b0, 1, 0, "p65535_1");
    run(16'd5, 16'd0, 16'hFFFF, 16'd5, 1'b1, 1, 0, "z5_0");
    run(16'd9, 16'd3, 16'd3, 16'd0, 1'b0, 17, 16, "g9_3");
    run(16'd3, 16'd10, 16'd0, 16'd3, 1'b0, 17, 16, "g3_10");
    run(16'd40000, 16'd40000, 16'd1, 16'd0, 1'b0, 17, 16, "g40000_eq");
    run(16'd0, 16'd7, 16'd0, 16'd0, 1'b0, 17, 16, "g0_7");

    // start with 50/6 during CALC must be ignored; then 50/6 back-to-back from FIN
    @(negedge clk);
    issue(16'd100, 16'd7, mk(16'd14, 16'd2, 1'b0));
    repeat (3) @(negedge clk);
    I = 16'd50;
    D = 16'd6;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(14, 13, "ignore");
    run(16'd50, 16'd6, 16'd8, 16'd2, 1'b0, 17, 16, "b2b50_6");

    // abort mid-CALC with reset: outputs clear without a clock edge, no done pulse
    @(negedge clk);
    I = 16'd100;
    D = 16'd7;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    rst_n = 1'b0;
    last_exp = '0;
    #1;
    chk_zero("async_rst");
    repeat (2) @(negedge clk);
    chk("rst_no_done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;
    run(16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 17, 16, "post_rst");

    // random sweep, biased to zero and power-of-two divisors, back-to-back
    for (int n = 0; n < 10000; n++) begin
      pick = $urandom_range(0, 7);
      if (pick < 2)      sd = 16'd0;
      else if (pick < 6) sd = 16'd1 << $urandom_range(0, 15);
      else               sd = 16'($urandom);
      pick = $urandom_range(0, 9);
      if (pick == 0)      si = 16'd0;
      else if (pick == 1) si = sd;
      else                si = 16'($urandom);
      if (sd == 16'd0) issue(si, sd, mk(16'hFFFF, si, 1'b1));
      else             issue(si, sd, mk(si / sd, si % sd, 1'b0));
      wait_done(-1, 0, "sweep");
    end

    @(negedge clk);
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
